count_sequencer: RTL and testbench

Command-driven controller for the team's counter datapath.
- Accepts a count job (start value, terminal value, direction, reload mode) over a valid/ready handshake.
- Steps the count on qualified tick strobes and flags terminal count.
- Either finishes (one-shot) or reloads and repeats (auto-reload).
- Sits between a control FSM/host and any logic needing timed or sequenced counts.

---
 rtl/count_sequencer.sv | 120 ++++++++++++
 tb/tb_count_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Command-driven count sequencer: accepts a count job over valid/ready, steps on ticks,
// flags terminal count and either finishes (one-shot) or reloads and repeats.
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int RLD_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_dir,
  input  logic             cmd_reload,
  input  logic             tick,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [RLD_W-1:0] reload_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RLD_W-1:0] RLD_ONE = {{(RLD_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [RLD_W-1:0] reload_cnt_q, reload_cnt_d;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      count_q      <= '0;
      start_q      <= '0;
      limit_q      <= '0;
      dir_q        <= 1'b0;
      reload_q     <= 1'b0;
      tc_q         <= 1'b0;
      reload_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      start_q      <= start_d;
      limit_q      <= limit_d;
      dir_q        <= dir_d;
      reload_q     <= reload_d;
      tc_q         <= tc_d;
      reload_cnt_q <= reload_cnt_d;
    end
  end

  // Priority in RUN: abort, then pause, then tick (terminal or step).
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    start_d      = start_q;
    limit_d      = limit_q;
    dir_d        = dir_q;
    reload_d     = reload_q;
    tc_d         = 1'b0;
    reload_cnt_d = reload_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          start_d      = cmd_start;
          limit_d      = cmd_limit;
          dir_d        = cmd_dir;
          reload_d     = cmd_reload;
          count_d      = cmd_start;
          reload_cnt_d = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause && tick) begin
          if (count_q == limit_q) begin
            tc_d = 1'b1;
            if (reload_q) begin
              count_d = start_q;
              if (reload_cnt_q != '1) begin
                reload_cnt_d = reload_cnt_q + RLD_ONE;
              end
            end else begin
              state_d = DONE;
            end
          end else if (dir_q) begin
            count_d = count_q - CNT_ONE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign tc         = tc_q;
  assign count      = count_q;
  assign reload_cnt = reload_cnt_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer (WIDTH=4, RLD_W=8).
module tb_count_sequencer;

  logic       clk;
  logic       RESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_start;
  logic [3:0] cmd_limit;
  logic       cmd_dir;
  logic       cmd_reload;
  logic       tick;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;
  logic [7:0] reload_cnt;

  int testCount = 0;
  int failCount = 0;

  count_sequencer #(.WIDTH(4), .RLD_W(8)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_limit  (cmd_limit),
    .cmd_dir    (cmd_dir),
    .cmd_reload (cmd_reload),
    .tick       (tick),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done),
    .reload_cnt (reload_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [3:0] expCount,
                            input logic expBusy, input logic expTc, input logic expDone);
    checkOutput({tag, ".count"}, {28'd0, count}, {28'd0, expCount});
    checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, expBusy});
    checkOutput({tag, ".tc"}, {31'd0, tc}, {31'd0, expTc});
    checkOutput({tag, ".done"}, {31'd0, done}, {31'd0, expDone});
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [3:0] l,
                               input logic d, input logic r);
    cmd_valid  = 1'b1;
    cmd_start  = s;
    cmd_limit  = l;
    cmd_dir    = d;
    cmd_reload = r;
    step();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    logic [3:0] downExp [4];
    logic [3:0] rldExp [9];
    downExp = '{4'd0, 4'd15, 4'd14, 4'd14};
    rldExp  = '{4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 4'd2};

    RESET = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_limit = '0;
    cmd_dir = 1'b0; cmd_reload = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;
    step(); step();
    checkFlags("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset.rcnt", {24'd0, reload_cnt}, 32'd0);
    RESET = 1'b0;
    step();

    // One-shot up 3..7
    applyStimulus(4'd3, 4'd7, 1'b0, 1'b0);
    checkFlags("up.accept", 4'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("up.ready", {31'd0, cmd_ready}, 32'd0);
    tick = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checkFlags("up.step", 4'(3 + i), 1'b1, 1'b0, 1'b0);
    end
    step();
    checkFlags("up.term", 4'd7, 1'b0, 1'b1, 1'b1);
    tick = 1'b0;
    step();
    checkFlags("up.idle", 4'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("up.ready2", {31'd0, cmd_ready}, 32'd1);

    // One-shot down 1..14 through the wrap
    applyStimulus(4'd1, 4'd14, 1'b1, 1'b0);
    checkFlags("down.accept", 4'd1, 1'b1, 1'b0, 1'b0);
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkFlags("down.step", downExp[i], (i != 3), (i == 3), (i == 3));
    end
    tick = 1'b0;
    step();
    checkFlags("down.idle", 4'd14, 1'b0, 1'b0, 1'b0);

    // Auto-reload up 2..4, nine ticks
    applyStimulus(4'd2, 4'd4, 1'b0, 1'b1);
    checkFlags("rld.accept", 4'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("rld.rcnt0", {24'd0, reload_cnt}, 32'd0);
    tick = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checkFlags("rld.step", rldExp[i], 1'b1, ((i % 3) == 2), 1'b0);
      checkOutput("rld.rcnt", {24'd0, reload_cnt}, 32'((i + 1) / 3));
    end
    tick = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    checkFlags("rld.abort", 4'd2, 1'b0, 1'b0, 1'b0);

    // Pause then abort-with-tick on a 0..15 one-shot
    applyStimulus(4'd0, 4'd15, 1'b0, 1'b0);
    tick = 1'b1;
    step(); step(); step();
    checkFlags("pz.pre", 4'd3, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkFlags("pz.hold", 4'd3, 1'b1, 1'b0, 1'b0);
    end
    pause = 1'b0;
    step(); step();
    checkFlags("pz.resume", 4'd5, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0; tick = 1'b0;
    checkFlags("pz.abort", 4'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("pz.ready", {31'd0, cmd_ready}, 32'd1);

    // start==limit, with a competing command held during RUN
    applyStimulus(4'd9, 4'd9, 1'b0, 1'b0);
    checkFlags("eq.accept", 4'd9, 1'b1, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_start = 4'd2; cmd_limit = 4'd5;
    tick = 1'b1;
    step();
    checkFlags("eq.term", 4'd9, 1'b0, 1'b1, 1'b1);
    checkOutput("eq.ready", {31'd0, cmd_ready}, 32'd0);
    step();
    checkFlags("eq.idle", 4'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("eq.ready2", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0; tick = 1'b0;
    checkFlags("eq.second", 4'd2, 1'b1, 1'b0, 1'b0);

    // Async reset between edges mid-RUN
    tick = 1'b1;
    step(); step();
    checkFlags("ar.pre", 4'd4, 1'b1, 1'b0, 1'b0);
    RESET = 1'b1;
    #2;
    checkFlags("ar.reset", 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ar.ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("ar.rcnt", {24'd0, reload_cnt}, 32'd0);
    tick = 1'b0;
    step();
    RESET = 1'b0;
    step();
    checkFlags("ar.after", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
